alu_issue_queue: RTL and testbench

// - Upstream issue stage for the 8-bit power ALU. Buffers {opcode, A, B} requests

---
 rtl/alu_issue_queue.sv | 155 +++++++++++++++
 tb/tb_alu_issue_queue.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// Issue queue in front of the 8-bit power ALU: FIFO of {opcode, A, B}, settle-timed
// issue to the datapath, and a valid/ready result port. Optional stats: ALU_ISSUE_QUEUE_STATS_EN.
module alu_issue_queue #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_opcode,
  input  logic [WIDTH-1:0]        in_a,
  input  logic [WIDTH-1:0]        in_b,
  output logic [3:0]              alu_opcode,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  input  logic [WIDTH-1:0]        alu_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_result,
  output logic [3:0]              out_opcode,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  count
`ifdef ALU_ISSUE_QUEUE_STATS_EN
  ,
  output logic [15:0]             issued,
  output logic [15:0]             stall
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 4 + 2 * WIDTH;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  logic [EW-1:0]    mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg, count_next;
  state_t           state_reg, state_next;
  logic [SW-1:0]    settle_reg, settle_next;
  logic [3:0]       alu_opcode_reg, out_opcode_reg;
  logic [WIDTH-1:0] alu_a_reg, alu_b_reg, out_result_reg;
  logic [EW-1:0]    head;
  logic             push, pop, capture;

  assign in_ready = (count_reg < FULL_COUNT);
  assign push     = in_valid && in_ready;
  assign head     = mem_reg[rd_ptr_reg];

  // Storage has no reset: occupancy is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= {in_opcode, in_a, in_b};
  end

  always_comb begin
    state_next  = state_reg;
    settle_next = settle_reg;
    pop         = 1'b0;
    capture     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (count_reg != '0) begin
          pop         = 1'b1;
          settle_next = SETTLE_LOAD;
          state_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (settle_reg == '0) begin
          capture    = 1'b1;
          state_next = S_DONE;
        end else begin
          settle_next = settle_reg - 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      settle_reg     <= '0;
      count_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      alu_opcode_reg <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      out_result_reg <= '0;
      out_opcode_reg <= '0;
    end else begin
      state_reg  <= state_next;
      settle_reg <= settle_next;
      count_reg  <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        rd_ptr_reg     <= rd_ptr_reg + 1'b1;
        alu_opcode_reg <= head[EW-1 -: 4];
        alu_a_reg      <= head[2*WIDTH-1 -: WIDTH];
        alu_b_reg      <= head[WIDTH-1:0];
      end
      // Sample the datapath only after alu_* has been held for SETTLE cycles.
      if (capture) begin
        out_result_reg <= alu_result;
        out_opcode_reg <= alu_opcode_reg;
      end
    end
  end

  assign alu_opcode = alu_opcode_reg;
  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign out_result = out_result_reg;
  assign out_opcode = out_opcode_reg;
  assign out_valid  = (state_reg == S_DONE);
  assign busy       = (state_reg != S_IDLE);
  assign count      = count_reg;

`ifdef ALU_ISSUE_QUEUE_STATS_EN
  logic [15:0] issued_reg, stall_reg;

  // issued wraps naturally; stall saturates so long stalls stay visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_reg <= '0;
      stall_reg  <= '0;
    end else begin
      if (pop) issued_reg <= issued_reg + 16'd1;
      if (in_valid && !in_ready && (stall_reg != 16'hFFFF)) stall_reg <= stall_reg + 16'd1;
    end
  end

  assign issued = issued_reg;
  assign stall  = stall_reg;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: queue-based scoreboard of accepted,
// issued and returned requests, plus directed latency/fill/reset scenarios.
module tb_alu_issue_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_opcode;
  logic [7:0] in_a, in_b;
  logic [3:0] alu_opcode;
  logic [7:0] alu_a, alu_b, alu_result;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [3:0] out_opcode;
  logic       busy;
  logic [2:0] count;
`ifdef ALU_ISSUE_QUEUE_STATS_EN
  logic [15:0] issued, stall;
`endif

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } req_t;

  req_t        issue_q[$];
  logic [11:0] res_q[$];
  int          checks = 0;
  int          errors = 0;
  int          issued_m = 0;
  int          stall_m = 0;

  always #5 clk = ~clk;

  alu_issue_queue dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_opcode(out_opcode),
    .busy(busy), .count(count)
`ifdef ALU_ISSUE_QUEUE_STATS_EN
    , .issued(issued), .stall(stall)
`endif
  );

  // Stand-in datapath; also used to predict each request's result.
  function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a - b;
      4'd4:    return a ^ b;
      4'd5:    return {a[6:0], 1'b0};
      default: return a + b + {4'h0, op};
    endcase
  endfunction

  assign alu_result = ref_alu(alu_opcode, alu_a, alu_b);

  task automatic load_req(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    in_opcode = op;
    in_a      = a;
    in_b      = b;
  endtask

  // One clock: scoreboard push/pop/return at the edge and check count and alu_* rules.
  task automatic step(output bit pushed);
    bit         push, pop, fire;
    int         exp_c;
    req_t       req, head;
    logic [3:0] op0;
    logic [7:0] a0, b0;
    logic [11:0] exp_r;
    push = in_valid && in_ready;
    pop  = !busy && (count != 3'd0);
    fire = out_valid && out_ready;
    exp_c = int'(count) + int'(push) - int'(pop);
    op0 = alu_opcode; a0 = alu_a; b0 = alu_b;
    req = '{op: in_opcode, a: in_a, b: in_b};
    if (in_valid && !in_ready && stall_m < 65535) stall_m++;
    if (fire) begin
      checks++;
      if (res_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got op=%0d res=%02h, required no result", out_opcode, out_result);
      end else begin
        exp_r = res_q.pop_front();
        if ({out_opcode, out_result} !== exp_r) begin
          errors++;
          $display("FAIL result_order: got op=%0d res=%02h, required op=%0d res=%02h",
                   out_opcode, out_result, exp_r[11:8], exp_r[7:0]);
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (int'(count) !== exp_c) begin
      errors++;
      $display("FAIL count_update: got %0d, required %0d (push=%0d pop=%0d)", count, exp_c, push, pop);
    end
    checks++;
    if (pop) begin
      issued_m++;
      if (issue_q.size() == 0) begin
        errors++;
        $display("FAIL pop_empty: popped with no queued request");
      end else begin
        head = issue_q.pop_front();
        if ({alu_opcode, alu_a, alu_b} !== {head.op, head.a, head.b}) begin
          errors++;
          $display("FAIL alu_issue: got op=%0d a=%02h b=%02h, required op=%0d a=%02h b=%02h",
                   alu_opcode, alu_a, alu_b, head.op, head.a, head.b);
        end
        res_q.push_back({head.op, ref_alu(head.op, head.a, head.b)});
      end
    end else if ({alu_opcode, alu_a, alu_b} !== {op0, a0, b0}) begin
      errors++;
      $display("FAIL alu_hold: got op=%0d a=%02h b=%02h, required op=%0d a=%02h b=%02h",
               alu_opcode, alu_a, alu_b, op0, a0, b0);
    end
    if (push) issue_q.push_back(req);
    pushed = push;
    $display("cycle push=%0d pop=%0d fire=%0d count=%0d", push, pop, fire, count);
  endtask

  task automatic clear_model();
    issue_q.delete();
    res_q.delete();
    issued_m = 0;
    stall_m  = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    load_req(4'd0, 8'd0, 8'd0);
    repeat (3) @(posedge clk);
    clear_model();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic timeout_fail(input string name);
    errors++;
    $display("FAIL %s: timed out, required completion", name);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({count, out_valid, busy, in_ready} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_ctrl: got count=%0d out_valid=%0d busy=%0d in_ready=%0d, required 0 0 0 1",
               count, out_valid, busy, in_ready);
    end
    checks++;
    if ({alu_opcode, alu_a, alu_b, out_result, out_opcode} !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: got alu=%0d/%02h/%02h out=%02h/%0d, required all 0",
               alu_opcode, alu_a, alu_b, out_result, out_opcode);
    end
  endtask

  task automatic test_single_op();
    bit p;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    load_req(4'd2, 8'h05, 8'h03);
    step(p);                              // edge 0: accept
    in_valid = 1'b0;
    checks++;
    if (p !== 1'b1 || count !== 3'd1 || alu_a !== 8'h00) begin
      errors++;
      $display("FAIL single_accept: got push=%0d count=%0d alu_a=%02h, required 1 1 00", p, count, alu_a);
    end
    step(p);                              // edge 1: issue
    checks++;
    if ({alu_opcode, alu_a, alu_b, out_valid, busy} !== {4'd2, 8'h05, 8'h03, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL single_issue: got op=%0d a=%02h b=%02h ov=%0d busy=%0d, required 2 05 03 0 1",
               alu_opcode, alu_a, alu_b, out_valid, busy);
    end
    step(p);                              // edge 2: settling
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: got out_valid=%0d at edge 2, required 0", out_valid);
    end
    step(p);                              // edge 3: result
    checks++;
    if ({out_valid, out_result, out_opcode} !== {1'b1, 8'h08, 4'd2}) begin
      errors++;
      $display("FAIL single_result: got ov=%0d res=%02h op=%0d, required 1 08 2", out_valid, out_result, out_opcode);
    end
    step(p);                              // edge 4: handshake
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_release: got ov=%0d busy=%0d, required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_fill();
    bit p;
    int sent = 0;
    int cyc = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    load_req(4'd4, 8'h10, 8'h01);
    repeat (8) begin
      step(p);
      if (p) begin
        sent++;
        load_req(4'(sent + 4), 8'(8'h10 + sent), 8'(sent));
      end
    end
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0 || busy !== 1'b1 || sent !== 5) begin
      errors++;
      $display("FAIL fill_full: got count=%0d in_ready=%0d busy=%0d accepted=%0d, required 4 0 1 5",
               count, in_ready, busy, sent);
    end
    out_ready = 1'b1;
    while ((sent < 6 || issue_q.size() != 0 || res_q.size() != 0) && cyc < 100) begin
      step(p);
      if (p) begin
        sent++;
        in_valid = 1'b0;
      end
      cyc++;
    end
    if (cyc >= 100) timeout_fail("fill_drain");
  endtask

  task automatic test_ordering();
    bit p;
    int sent = 0;
    int cyc = 0;
    in_valid = 1'b0;
    while ((sent < 8 || issue_q.size() != 0 || res_q.size() != 0) && cyc < 400) begin
      if (!in_valid && sent < 8 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        load_req(4'($urandom_range(0, 15)), 8'(sent), 8'($urandom_range(0, 255)));
      end
      out_ready = 1'($urandom_range(0, 1));
      step(p);
      if (p) begin
        sent++;
        in_valid = 1'b0;
      end
      cyc++;
    end
    if (cyc >= 400) timeout_fail("ordering");
  endtask

  task automatic test_wrap();
    bit p;
    bit reached = 1'b0;
    int sent = 0;
    int cyc = 0;
    out_ready = 1'b1;
    while ((sent < 20 || issue_q.size() != 0 || res_q.size() != 0) && cyc < 400) begin
      if (sent < 20) begin
        in_valid = (count < 3'd2) || !busy;
        load_req(4'(sent % 16), 8'(sent * 7), 8'(~sent));
      end else begin
        in_valid = 1'b0;
      end
      step(p);
      if (p) sent++;
      if (reached && sent < 20) begin
        checks++;
        if (count !== 3'd2) begin
          errors++;
          $display("FAIL wrap_steady: got count=%0d, required 2", count);
        end
      end
      if (count == 3'd2) reached = 1'b1;
      cyc++;
    end
    if (cyc >= 400) timeout_fail("wrap");
  endtask

  task automatic test_reset_mid_op();
    bit p;
    int cyc = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    while (!(busy && !out_valid && count == 3'd3) && cyc < 40) begin
      load_req(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      step(p);
      cyc++;
    end
    if (cyc >= 40) timeout_fail("reset_mid_setup");
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, count, alu_opcode, alu_a, alu_b} !== 25'd0) begin
      errors++;
      $display("FAIL reset_mid: got ov=%0d busy=%0d count=%0d alu=%0d/%02h/%02h, required all 0",
               out_valid, busy, count, alu_opcode, alu_a, alu_b);
    end
    clear_model();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (12) begin
      step(p);
      checks++;
      if (out_valid !== 1'b0 || count !== 3'd0) begin
        errors++;
        $display("FAIL reset_stale: got ov=%0d count=%0d, required 0 0", out_valid, count);
      end
    end
  endtask

`ifdef ALU_ISSUE_QUEUE_STATS_EN
  task automatic test_stats();
    bit p;
    int sent = 0;
    int cyc = 0;
    apply_reset();
    in_valid = 1'b1;
    load_req(4'd1, 8'hA0, 8'h0F);
    while (sent < 5 && cyc < 20) begin
      step(p);
      if (p) sent++;
      cyc++;
    end
    repeat (4) step(p);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (issued_m < 3 && cyc < 40) begin
      step(p);
      cyc++;
    end
    if (cyc >= 40) timeout_fail("stats_pops");
    checks++;
    if (issued !== 16'd3 || stall !== 16'd4) begin
      errors++;
      $display("FAIL stats: got issued=%0d stall=%0d, required 3 4", issued, stall);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    load_req(4'd0, 8'd0, 8'd0);
    test_reset();
    test_single_op();
    test_fill();
    test_ordering();
    test_wrap();
    test_reset_mid_op();
`ifdef ALU_ISSUE_QUEUE_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
